// File: rtl/shift_register_univ.sv
// Universal shift register: parallel load, hold, shift and rotate in both
// directions under clock enable, with serial taps at both ends. A saturating
// operation counter tracks shifts since the last load and raises a one-cycle
// done pulse on the WIDTH-th shift, i.e. when a loaded word has fully left.
module shift_register_univ #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   localparam int              CW        = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             ce,
   input  logic             sclr,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin_l,
   input  logic             sin_r,
   output logic [WIDTH-1:0] q,
   output logic             sout_l,
   output logic             sout_r,
   output logic [CW-1:0]    cnt,
   output logic             done
);

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_LOAD = 3'b001;
   localparam logic [2:0] MODE_SHL  = 3'b010;
   localparam logic [2:0] MODE_SHR  = 3'b011;
   localparam logic [2:0] MODE_ROL  = 3'b100;
   localparam logic [2:0] MODE_ROR  = 3'b101;

   // cnt saturates at WIDTH; the edge leaving WIDTH-1 is the one that fires done
   localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] data_q, data_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             is_shift;

   // Next-state: sclr beats ce, ce=0 freezes everything, otherwise mode decides
   always_comb begin
      data_d   = data_q;
      cnt_d    = cnt_q;
      done_d   = done_q;
      is_shift = 1'b0;
      if (sclr) begin
         data_d = RESET_VAL;
         cnt_d  = '0;
         done_d = 1'b0;
      end else if (ce) begin
         case (mode)
            MODE_LOAD: begin
               data_d = d;
               cnt_d  = '0;
            end
            MODE_SHL: begin
               data_d   = {data_q[WIDTH-2:0], sin_r};
               is_shift = 1'b1;
            end
            MODE_SHR: begin
               data_d   = {sin_l, data_q[WIDTH-1:1]};
               is_shift = 1'b1;
            end
            MODE_ROL: begin
               data_d   = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
               is_shift = 1'b1;
            end
            MODE_ROR: begin
               data_d   = {data_q[0], data_q[WIDTH-1:1]};
               is_shift = 1'b1;
            end
            default: begin
               // HOLD and the two reserved codes leave data and count alone
               data_d = data_q;
            end
         endcase
         // Direction is irrelevant: cnt counts operations, not bit position
         if (is_shift && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CW'(1);
         end
         // Any enabled edge clears a pending pulse unless this one re-fires it
         done_d = is_shift && (cnt_q == CNT_LAST);
      end
   end

   // State registers; async clear aborts any shift sequence in progress
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         data_q <= RESET_VAL;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         data_q <= data_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   // Outputs are straight views of the registers
   always_comb begin
      q      = data_q;
      sout_l = data_q[WIDTH-1];
      sout_r = data_q[0];
      cnt    = cnt_q;
      done   = done_q;
   end

   // MODE_HOLD is listed for readability; the default branch implements it
   logic unused_hold;
   assign unused_hold = ^MODE_HOLD;

endmodule
